// File: rtl/stopwatch_fsm_bcd_if.sv
// Button inputs and status/display outputs of the stopwatch controller.
// The slave modport is the controller's view; master is the board/driver side.
interface stopwatch_fsm_bcd_if #(
  parameter int DIGITS = 4
);
  logic                  i_start;
  logic                  i_pause;
  logic                  i_clear;
  logic                  o_idle;
  logic                  o_running;
  logic                  o_paused;
  logic                  o_done;
  logic                  o_tick;
  logic [4*DIGITS-1:0]   o_bcd;
  logic [7*DIGITS-1:0]   o_seven;

  modport master (
    output i_start, i_pause, i_clear,
    input  o_idle, o_running, o_paused, o_done, o_tick, o_bcd, o_seven
  );

  modport slave (
    input  i_start, i_pause, i_clear,
    output o_idle, o_running, o_paused, o_done, o_tick, o_bcd, o_seven
  );
endinterface

// File: rtl/stopwatch_fsm_bcd.sv
// Stopwatch/timer controller: IDLE/RUN/PAUSE/DONE FSM with a tick prescaler,
// a multi-digit BCD up/down count and registered active-low seven-segment glyphs.
module stopwatch_fsm_bcd #(
  parameter int TICK_CNT   = 50_000_000,
  parameter int DIGITS     = 4,
  parameter int TARGET     = 5,
  parameter int DONE_HOLD  = 1,
  parameter bit COUNT_DOWN = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  stopwatch_fsm_bcd_if.slave sw
);

  localparam int BW     = 4 * DIGITS;
  localparam int SW     = 7 * DIGITS;
  localparam int PRE_W  = $clog2(TICK_CNT);
  localparam int HOLD_W = $clog2(DONE_HOLD + 1);

  function automatic logic [BW-1:0] to_bcd(input int value);
    logic [BW-1:0] r;
    int            v;
    r = '0;
    v = value;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v           = v / 10;
    end
    return r;
  endfunction

  // Ripple +1/-1 across digits: 9->0 carries upward, 0->9 borrows upward.
  function automatic logic [BW-1:0] bcd_step(input logic [BW-1:0] b, input logic down);
    logic [BW-1:0] r;
    logic          carry;
    logic [3:0]    dg;
    r     = b;
    carry = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      dg = b[4*d +: 4];
      if (carry) begin
        if (down) begin
          if (dg == 4'd0) r[4*d +: 4] = 4'd9;
          else begin
            r[4*d +: 4] = dg - 4'd1;
            carry       = 1'b0;
          end
        end else begin
          if (dg >= 4'd9) r[4*d +: 4] = 4'd0;
          else begin
            r[4*d +: 4] = dg + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] dg);
    logic [6:0] s;
    case (dg)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  function automatic logic [SW-1:0] seg_all(input logic [BW-1:0] b);
    logic [SW-1:0] r;
    r = '1;
    for (int d = 0; d < DIGITS; d++) r[7*d +: 7] = seg7(b[4*d +: 4]);
    return r;
  endfunction

  localparam logic [BW-1:0]     START_BCD = to_bcd(COUNT_DOWN ? TARGET : 0);
  localparam logic [BW-1:0]     TERM_BCD  = to_bcd(COUNT_DOWN ? 0 : TARGET);
  localparam logic [PRE_W-1:0]  PRE_MAX   = PRE_W'(TICK_CNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DONE_HOLD - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t            state, state_nxt;
  logic [PRE_W-1:0]  pre, pre_nxt;
  logic [HOLD_W-1:0] hold, hold_nxt;
  logic [BW-1:0]     bcd, bcd_nxt, bcd_adv;
  logic [SW-1:0]     seven;
  logic              prev_start, prev_pause, prev_clear;
  logic              start_edge, pause_edge, clear_edge, tick;

  assign start_edge = sw.i_start & ~prev_start;
  assign pause_edge = sw.i_pause & ~prev_pause;
  assign clear_edge = sw.i_clear & ~prev_clear;
  assign tick       = ((state == RUN) || (state == DONE)) && (pre == PRE_MAX);
  assign bcd_adv    = bcd_step(bcd, COUNT_DOWN);

  always_comb begin
    state_nxt = state;
    pre_nxt   = pre;
    hold_nxt  = hold;
    bcd_nxt   = bcd;
    case (state)
      IDLE: begin
        pre_nxt  = '0;
        hold_nxt = '0;
        bcd_nxt  = START_BCD;
        if (start_edge && !clear_edge) state_nxt = RUN;
      end
      RUN: begin
        pre_nxt = tick ? '0 : pre + 1'b1;
        if (clear_edge) begin
          state_nxt = IDLE;
          pre_nxt   = '0;
          bcd_nxt   = START_BCD;
        end else if (tick && ((bcd == TERM_BCD) || (bcd_adv == TERM_BCD))) begin
          // Covers both reaching terminal and a terminal start value (TARGET=0).
          state_nxt = DONE;
          hold_nxt  = '0;
          bcd_nxt   = TERM_BCD;
        end else begin
          if (tick)       bcd_nxt   = bcd_adv;
          if (pause_edge) state_nxt = PAUSE;
        end
      end
      PAUSE: begin
        if (clear_edge) begin
          state_nxt = IDLE;
          pre_nxt   = '0;
          bcd_nxt   = START_BCD;
        end else if (start_edge) begin
          state_nxt = RUN;
        end
      end
      DONE: begin
        pre_nxt = tick ? '0 : pre + 1'b1;
        if (clear_edge || (tick && (hold == HOLD_LAST))) begin
          state_nxt = IDLE;
          pre_nxt   = '0;
          bcd_nxt   = START_BCD;
        end else if (tick) begin
          hold_nxt = hold + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Register stage: FSM, prescaler, count and glyphs all advance on one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pre        <= '0;
      hold       <= '0;
      bcd        <= START_BCD;
      seven      <= '1;
      prev_start <= 1'b1;
      prev_pause <= 1'b1;
      prev_clear <= 1'b1;
    end else begin
      state      <= state_nxt;
      pre        <= pre_nxt;
      hold       <= hold_nxt;
      bcd        <= bcd_nxt;
      seven      <= seg_all(bcd_nxt);
      prev_start <= sw.i_start;
      prev_pause <= sw.i_pause;
      prev_clear <= sw.i_clear;
    end
  end

  assign sw.o_idle    = (state == IDLE);
  assign sw.o_running = (state == RUN);
  assign sw.o_paused  = (state == PAUSE);
  assign sw.o_done    = (state == DONE);
  assign sw.o_tick    = tick;
  assign sw.o_bcd     = bcd;
  assign sw.o_seven   = seven;

endmodule
